// File: rtl/shot_control_pkg.sv
// rtl/shot_control_pkg.sv - shared constants, request codes and FSM states for shot_control
package shot_control_pkg;

  localparam logic [1:0] FUNC_READ = 2'b00;
  localparam logic [1:0] FUNC_HIT  = 2'b01;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int BLK_W_LOG2 = 5;
  localparam int BLK_H_LOG2 = 4;
  localparam int BLK_ROWS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_MOVE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_HIT_REQ,
    ST_HIT_WAIT,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/shot_control_if.sv
// rtl/shot_control_if.sv - block_memory request/response port used by shot_control
interface shot_control_if;

  logic       bm_enable;
  logic [4:0] bm_row;
  logic [4:0] bm_col;
  logic [1:0] bm_func;
  logic       bm_ready;
  logic [3:0] bm_block;

  modport master (
    output bm_enable, bm_row, bm_col, bm_func,
    input  bm_ready, bm_block
  );

  modport slave (
    input  bm_enable, bm_row, bm_col, bm_func,
    output bm_ready, bm_block
  );

endinterface

// File: rtl/shot_control_tick_gen.sv
// rtl/shot_control_tick_gen.sv - enable-gated divider producing a one-cycle tick every DIV enabled cycles
module shot_control_tick_gen #(
  parameter int DIV = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap   = (cnt_q == W'(DIV - 1));
  assign tick_o = en_i && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shot_control.sv
// rtl/shot_control.sv - spawns, moves and collision-checks paddle shots against the block grid
module shot_control
  import shot_control_pkg::*;
#(
  parameter int SHOT_NUM     = 2,
  parameter int TICK_DIV     = 500000,
  parameter int SHOT_SPEED   = 4,
  parameter int BLOCK_W_LOG2 = BLK_W_LOG2,
  parameter int BLOCK_H_LOG2 = BLK_H_LOG2,
  parameter int BLOCK_ROWS   = BLK_ROWS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fire,
  input  logic [9:0]             p_x,
  input  logic [9:0]             p_y,
  shot_control_if.master         bm,
  output logic [SHOT_NUM*10-1:0] s_x,
  output logic [SHOT_NUM*10-1:0] s_y,
  output logic [SHOT_NUM-1:0]    s_active,
  output logic                   hit
);

  localparam int IW = (SHOT_NUM > 1) ? $clog2(SHOT_NUM) : 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [9:0]          x_q [SHOT_NUM];
  logic [9:0]          x_d [SHOT_NUM];
  logic [9:0]          y_q [SHOT_NUM];
  logic [9:0]          y_d [SHOT_NUM];
  logic [SHOT_NUM-1:0] active_q, active_d;
  logic                fire_pend_q, fire_pend_d;
  logic                tick_pend_q, tick_pend_d;
  logic [4:0]          row_q, row_d, col_q, col_d;
  logic [1:0]          func_q, func_d;
  logic                hit_q, hit_d;

  logic                tick;
  logic                spawn_ok;
  logic [IW-1:0]       spawn_idx;
  logic [9:0]          ny;
  logic [4:0]          row_calc, col_calc;

  shot_control_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .en_i   (enable),
    .tick_o (tick)
  );

  assign ny       = y_q[idx_q] - 10'(SHOT_SPEED);
  assign row_calc = 5'(ny >> BLOCK_H_LOG2);
  assign col_calc = 5'(x_q[idx_q] >> BLOCK_W_LOG2);

  always_comb begin
    spawn_ok  = 1'b0;
    spawn_idx = '0;
    for (int k = SHOT_NUM - 1; k >= 0; k--) begin
      if (!active_q[k]) begin
        spawn_ok  = 1'b1;
        spawn_idx = IW'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    active_d    = active_q;
    fire_pend_d = fire_pend_q | (fire & enable);
    tick_pend_d = tick_pend_q;
    row_d       = row_q;
    col_d       = col_q;
    func_d      = func_q;
    hit_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire_pend_q) begin
          state_d = ST_SPAWN;
        end else if (tick_pend_q) begin
          state_d     = ST_MOVE;
          idx_d       = '0;
          tick_pend_d = 1'b0;
        end
      end
      ST_SPAWN: begin
        if (spawn_ok) begin
          x_d[spawn_idx]      = p_x;
          y_d[spawn_idx]      = p_y - 10'd1;
          active_d[spawn_idx] = 1'b1;
        end
        // a fire landing in this very cycle is kept for the next spawn
        fire_pend_d = fire & enable;
        state_d     = ST_IDLE;
      end
      ST_MOVE: begin
        state_d = ST_NEXT;
        if (active_q[idx_q]) begin
          if (int'(y_q[idx_q]) < SHOT_SPEED) begin
            active_d[idx_q] = 1'b0;
          end else begin
            y_d[idx_q] = ny;
            row_d      = row_calc;
            col_d      = col_calc;
            func_d     = FUNC_READ;
            if (int'(row_calc) < BLOCK_ROWS) state_d = ST_READ_REQ;
          end
        end
      end
      ST_READ_REQ: state_d = ST_READ_WAIT;
      ST_READ_WAIT: begin
        if (bm.bm_ready) begin
          if (bm.bm_block != 4'd0) begin
            func_d  = FUNC_HIT;
            state_d = ST_HIT_REQ;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_HIT_REQ: state_d = ST_HIT_WAIT;
      ST_HIT_WAIT: begin
        if (bm.bm_ready) begin
          active_d[idx_q] = 1'b0;
          hit_d           = 1'b1;
          state_d         = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (int'(idx_q) == SHOT_NUM - 1) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_MOVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tick_pend_d = tick_pend_d | tick;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      active_q    <= '0;
      fire_pend_q <= 1'b0;
      tick_pend_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      func_q      <= FUNC_READ;
      hit_q       <= 1'b0;
      for (int k = 0; k < SHOT_NUM; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      fire_pend_q <= fire_pend_d;
      tick_pend_q <= tick_pend_d;
      row_q       <= row_d;
      col_q       <= col_d;
      func_q      <= func_d;
      hit_q       <= hit_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign bm.bm_enable = (state_q == ST_READ_REQ) || (state_q == ST_HIT_REQ);
  assign bm.bm_row    = row_q;
  assign bm.bm_col    = col_q;
  assign bm.bm_func   = func_q;
  assign s_active     = active_q;
  assign hit          = hit_q;

  always_comb begin
    s_x = '0;
    s_y = '0;
    for (int k = 0; k < SHOT_NUM; k++) begin
      s_x[10*k +: 10] = x_q[k];
      s_y[10*k +: 10] = y_q[k];
    end
  end

endmodule

// File: tb/tb_shot_control.sv
// tb/tb_shot_control.sv - directed self-checking bench for shot_control with a simple block_memory responder
module tb_shot_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        fire = 1'b0;
  logic [9:0]  p_x = '0;
  logic [9:0]  p_y = '0;
  logic [19:0] s_x, s_y;
  logic [1:0]  s_active;
  logic        hit;

  logic        mem_ready;
  logic [3:0]  mem_val = 4'd0;
  logic        mem_hold = 1'b0;
  logic [1:0]  mem_wait;

  int          n_checks = 0;
  int          n_fail = 0;
  int          en_cycles = 0;
  int          strobe_cnt;
  int          hit_cnt;
  logic [4:0]  req_row [8];
  logic [4:0]  req_col [8];
  logic [1:0]  req_func [8];

  shot_control_if bm ();

  shot_control #(
    .SHOT_NUM   (2),
    .TICK_DIV   (10),
    .SHOT_SPEED (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .fire     (fire),
    .p_x      (p_x),
    .p_y      (p_y),
    .bm       (bm),
    .s_x      (s_x),
    .s_y      (s_y),
    .s_active (s_active),
    .hit      (hit)
  );

  always #10 clock = ~clock;

  assign bm.bm_ready = mem_ready;
  assign bm.bm_block = mem_val;

  // responds two cycles after each strobe unless held off
  always @(posedge clock) begin
    mem_ready <= 1'b0;
    if (reset) begin
      mem_wait <= 2'd0;
    end else if (bm.bm_enable) begin
      mem_wait <= 2'd2;
    end else if (mem_wait == 2'd1) begin
      if (!mem_hold) begin
        mem_ready <= 1'b1;
        mem_wait  <= 2'd0;
      end
    end else if (mem_wait != 2'd0) begin
      mem_wait <= mem_wait - 2'd1;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      strobe_cnt <= 0;
      hit_cnt    <= 0;
    end else begin
      if (bm.bm_enable && strobe_cnt < 8) begin
        req_row[strobe_cnt]  <= bm.bm_row;
        req_col[strobe_cnt]  <= bm.bm_col;
        req_func[strobe_cnt] <= bm.bm_func;
        strobe_cnt           <= strobe_cnt + 1;
      end
      if (hit) hit_cnt <= hit_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    fire   = 1'b0;
    @(negedge clock);
    reset     = 1'b0;
    en_cycles = 0;
  endtask

  task automatic fire_pulse(input logic [9:0] x, input logic [9:0] y);
    p_x    = x;
    p_y    = y;
    fire   = 1'b1;
    enable = 1'b1;
    @(negedge clock);
    fire   = 1'b0;
    enable = 1'b0;
    en_cycles++;
  endtask

  task automatic spawn(input logic [9:0] x, input logic [9:0] y);
    fire_pulse(x, y);
    repeat (4) @(negedge clock);
  endtask

  task automatic tick_now();
    int n;
    n = 10 - (en_cycles % 10);
    enable = 1'b1;
    repeat (n) @(negedge clock);
    enable = 1'b0;
    en_cycles += n;
  endtask

  initial begin
    do_reset();
    check("rst_active", 32'(s_active), 32'd0);
    check("rst_sx", 32'(s_x), 32'd0);
    check("rst_sy", 32'(s_y), 32'd0);
    check("rst_bm_en", 32'(bm.bm_enable), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);

    fire_pulse(10'd320, 10'd440);
    repeat (2) @(negedge clock);
    check("spawn_active", 32'(s_active), 32'b01);
    check("spawn_x0", 32'(s_x[9:0]), 32'd320);
    check("spawn_y0", 32'(s_y[9:0]), 32'd439);

    repeat (2) @(negedge clock);
    spawn(10'd100, 10'd300);
    spawn(10'd500, 10'd50);
    check("full_active", 32'(s_active), 32'b11);
    check("full_x1", 32'(s_x[19:10]), 32'd100);
    check("full_y1", 32'(s_y[19:10]), 32'd299);
    check("full_x0_kept", 32'(s_x[9:0]), 32'd320);
    check("full_no_req", 32'(strobe_cnt), 32'd0);

    do_reset();
    mem_val = 4'd0;
    spawn(10'd320, 10'd132);
    tick_now();
    repeat (30) @(negedge clock);
    check("miss_y", 32'(s_y[9:0]), 32'd127);
    check("miss_reqs", 32'(strobe_cnt), 32'd1);
    check("miss_row", 32'(req_row[0]), 32'd7);
    check("miss_col", 32'(req_col[0]), 32'd10);
    check("miss_func", 32'(req_func[0]), 32'd0);
    check("miss_active", 32'(s_active), 32'b01);
    check("miss_hits", 32'(hit_cnt), 32'd0);

    do_reset();
    mem_val = 4'h3;
    spawn(10'd320, 10'd132);
    tick_now();
    repeat (30) @(negedge clock);
    check("hit_reqs", 32'(strobe_cnt), 32'd2);
    check("hit_rd_func", 32'(req_func[0]), 32'd0);
    check("hit_func", 32'(req_func[1]), 32'd1);
    check("hit_row", 32'(req_row[1]), 32'd7);
    check("hit_col", 32'(req_col[1]), 32'd10);
    check("hit_pulses", 32'(hit_cnt), 32'd1);
    check("hit_active", 32'(s_active), 32'b00);
    mem_val = 4'd0;

    do_reset();
    spawn(10'd40, 10'd4);
    spawn(10'd50, 10'd201);
    check("edge_pre_y", 32'(s_y), {22'd0, 10'd200, 10'd3});
    tick_now();
    repeat (20) @(negedge clock);
    check("edge_active", 32'(s_active), 32'b10);
    check("edge_y1", 32'(s_y[19:10]), 32'd196);
    check("edge_no_req", 32'(strobe_cnt), 32'd0);

    do_reset();
    mem_hold = 1'b1;
    spawn(10'd320, 10'd132);
    tick_now();
    repeat (5) @(negedge clock);
    check("abort_req_seen", 32'(strobe_cnt), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    en_cycles = 0;
    mem_hold  = 1'b0;
    check("abort_active", 32'(s_active), 32'd0);
    check("abort_row", 32'(bm.bm_row), 32'd0);
    check("abort_col", 32'(bm.bm_col), 32'd0);
    check("abort_bm_en", 32'(bm.bm_enable), 32'd0);
    check("abort_sy", 32'(s_y), 32'd0);
    repeat (5) @(negedge clock);
    check("abort_idle", 32'(bm.bm_enable), 32'd0);
    spawn(10'd64, 10'd100);
    check("respawn_active", 32'(s_active), 32'b01);
    check("respawn_x", 32'(s_x[9:0]), 32'd64);
    check("respawn_y", 32'(s_y[9:0]), 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_control.md
Name: shot_control

Overview:
- Manages up to SHOT_NUM paddle laser shots: spawns on a fire pulse, advances them upward on a fixed game tick, and checks each shot against the block grid.
- Sits beside state_control, upstream of block_memory (port 1: bm_enable/bm_row/bm_col/bm_func, bm_block/bm_ready) and of the draw stage (shot positions/active flags).
- Fed by syn_edge_detect (fire pulse) and paddle_control (p_x, p_y).

Parameters:
SHOT_NUM, 2, number of shot slots
TICK_DIV, 500000, clock cycles per movement tick (100 Hz at 50 MHz)
SHOT_SPEED, 4, pixels moved upward per tick
BLOCK_W_LOG2, 5, log2 block width in pixels (32)
BLOCK_H_LOG2, 4, log2 block height in pixels (16)
BLOCK_ROWS, 8, grid rows; rows >= BLOCK_ROWS have no blocks

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
enable  in  1  1 = game running; 0 freezes tick counter and ignores fire
fire  in  1  single-cycle fire pulse
p_x  in  10  paddle centre x
p_y  in  10  paddle top y
bm_ready  in  1  block_memory response valid
bm_block  in  4  block value at requested row/col (0 = empty)
bm_enable  out  1  one-cycle request strobe
bm_row  out  5  requested row
bm_col  out  5  requested column
bm_func  out  2  request type: 2'b00 READ, 2'b01 HIT (damage/remove)
s_x  out  SHOT_NUM*10  packed shot x, slot i at [10i+9:10i]
s_y  out  SHOT_NUM*10  packed shot y
s_active  out  SHOT_NUM  per-slot active flag
hit  out  1  one-cycle pulse when a shot destroys/damages a block

Behaviour:
- Reset: s_x=s_y=0, s_active=0, bm_enable=0, bm_row=bm_col=0, bm_func=00, hit=0, tick counter=0, pending flags cleared, FSM=IDLE.
- Tick counter: counts 0..TICK_DIV-1 while enable=1; at wrap it sets tick_pend. Holds its value while enable=0.
- fire while enable=1 sets fire_pend (sticky until serviced); repeated fires while pending merge into one.
- FSM states: IDLE, SPAWN, MOVE, READ_REQ, READ_WAIT, HIT_REQ, HIT_WAIT, NEXT.
- IDLE: fire_pend has priority -> SPAWN; else tick_pend -> MOVE with index i=0 and tick_pend cleared.
- SPAWN (1 cycle): lowest-index inactive slot gets x=p_x, y=p_y-1, active=1; if every slot is active, the fire is dropped. fire_pend cleared -> IDLE.
- MOVE: if slot i is inactive -> NEXT. If y < SHOT_SPEED: active=0 -> NEXT. Otherwise y -= SHOT_SPEED. Then row = y>>BLOCK_H_LOG2 and col = x>>BLOCK_W_LOG2, both truncated to 5 bits. If row >= BLOCK_ROWS -> NEXT, else -> READ_REQ.
- READ_REQ: drive bm_row/bm_col with func READ and pulse bm_enable for one cycle -> READ_WAIT.
- Request handshake: row/col/func stay stable from the strobe cycle until the response is consumed. The response is the first cycle at least one cycle after the strobe with bm_ready=1.
- READ_WAIT: on response, bm_block != 0 -> HIT_REQ; else -> NEXT.
- HIT_REQ: pulse bm_enable with func HIT, same row/col -> HIT_WAIT.
- HIT_WAIT: on response, active[i]=0 and hit=1 for one cycle -> NEXT.
- NEXT: i==SHOT_NUM-1 -> IDLE, else i+1 -> MOVE.
- Ticks and fires arriving mid-scan stay pending and are serviced from IDLE. A tick arriving while tick_pend is already set is lost; one move per serviced tick.
- Worst-case scan must finish well inside TICK_DIV; no timeout on bm_ready.
- enable=0 mid-scan: the current scan completes, and no new ticks or fires are accepted.
- Synchronous reset mid-handshake aborts immediately to reset values. block_memory tolerates an abandoned request.

Decomposition:
- Shared package/header: FUNC_READ=2'b00, FUNC_HIT=2'b01, screen size 640x480, block geometry constants, shared with block_memory and state_control.
- One natural sub-module: tick_gen (parameterised divider with enable, one-cycle tick output). It is reusable for ball movement.

Test Plan:
- Reset, then fire with p_x=320, p_y=440 -> slot0 active, s_x[9:0]=320, s_y[9:0]=439 within 3 cycles; slot1 inactive.
- Three fires with both slots already active -> third fire dropped, s_active stays 2'b11, no bm_enable activity.
- Shot at y=131 with TICK_DIV=10 and memory returning 0 -> after a tick, y=127 and a READ request with row=7, col=10; no HIT request, shot stays active.
- Same shot with memory returning 4'h3 -> READ then HIT to row 7/col 10, then hit pulses once and s_active[0]=0.
- Shot at y=3 -> on tick, s_active[0] falls to 0 with no memory request. Shot at y=200 -> moves to 196, row 12 >= 8, no request.
- Assert reset while in READ_WAIT with bm_ready held low -> next cycle all outputs at reset values; a subsequent fire spawns normally.
